// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants,
// the fetch FSM state type and the default reset PC.
package instruction_fetch_pkg;

   // Major opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Address of the first fetch after reset
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   // Clears the byte-offset bits so an address is always word aligned
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_sel.sv
// Combinational next-PC selection: jump target, taken branch target or
// the sequential address. Jump wins over branch; branch and branch_ne
// may both be high and simply OR together through the taken equation.
module next_pc_sel
   import instruction_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        branch_ne,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] pc_plus4;
   logic [29:0] imm_ext;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        taken;
   logic        unused_opcode;

   // The opcode field plays no part in target computation
   assign unused_opcode = &{1'b0, instr[31:26]};

   // Sign-extend the 16-bit branch offset to 30 bits; the <<2 is the
   // concatenation below, so bits 31:30 of the extension are never needed
   generate
      for (genvar gi = 0; gi < 30; gi++) begin : g_imm_ext
         if (gi < 16) begin : g_low
            assign imm_ext[gi] = instr[gi];
         end else begin : g_sign
            assign imm_ext[gi] = instr[15];
         end
      end
   endgenerate

   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + {imm_ext, 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign taken         = (branch & zero) | (branch_ne & ~zero);

   // Priority select: jump, then taken branch, then fall-through
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (taken) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE -> FETCH (request until ack) -> HOLD
// (present instruction until retired) -> FETCH at the computed next PC.
// Optional retired-instruction counter enabled by defining FETCH_COUNT_EN.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc,
   input  logic        branch,
   input  logic        branch_ne,
   input  logic        jump,
`ifdef FETCH_COUNT_EN
   output logic [31:0] fetch_count,
`endif
   input  logic        zero
);

   localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  next_pc;
   logic         retire;

   next_pc_sel u_next_pc_sel (
      .pc        (pc_reg),
      .instr     (instr_reg),
      .branch    (branch),
      .branch_ne (branch_ne),
      .jump      (jump),
      .zero      (zero),
      .next_pc   (next_pc)
   );

   // State, PC and instruction registers; reset aborts any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC_ALIGNED;
         instr_reg <= '0;
      end else begin
         state_reg <= state_next;
         instr_reg <= instr_next;
         if (retire) begin
            pc_reg <= next_pc;
         end
      end
   end

   // Next-state and output decode; ack and ready only count in their own state
   always_comb begin
      state_next  = state_reg;
      instr_next  = instr_reg;
      retire      = 1'b0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_next = imem_rdata;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               retire     = 1'b1;
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign instr     = instr_reg;
   assign opcode    = instr_reg[31:26];

`ifdef FETCH_COUNT_EN
   logic [31:0] count_reg;

   // Count retired instructions; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (retire) begin
         count_reg <= count_reg + 32'd1;
      end
   end

   assign fetch_count = count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. Inputs are driven and outputs
// sampled on the falling edge. A second instance with a high, misaligned
// RESET_PC shares all inputs and is used for the jump-region check.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, imem_ack, instr_ready, branch, branch_ne, jump, zero;
   logic [31:0] imem_rdata;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, pc;
   logic [5:0]  opcode;
   logic        hi_imem_req, hi_instr_valid;
   logic [31:0] hi_imem_addr, hi_instr, hi_pc;
   logic [5:0]  hi_opcode;
`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count, hi_fetch_count;
`endif

   instruction_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
      .branch(branch), .branch_ne(branch_ne), .jump(jump),
`ifdef FETCH_COUNT_EN
      .fetch_count(fetch_count),
`endif
      .zero(zero)
   );

   instruction_fetch #(.RESET_PC(32'h2000_0003)) dut_hi (
      .clk(clk), .rst_n(rst_n), .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(hi_instr), .opcode(hi_opcode),
      .instr_valid(hi_instr_valid), .instr_ready(instr_ready), .pc(hi_pc),
      .branch(branch), .branch_ne(branch_ne), .jump(jump),
`ifdef FETCH_COUNT_EN
      .fetch_count(hi_fetch_count),
`endif
      .zero(zero)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_pc;
   int          model_count;

   // Reference next-PC: plain arithmetic on the architectural rules
   function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic br, input logic bne,
                                               input logic j, input logic z);
      logic [31:0] seq;
      logic [15:0] imm;
      int          off;
      seq = cur + 32'd4;
      imm = ins[15:0];
      off = $signed(imm);
      if (j) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
      if ((br && z) || (bne && !z)) return seq + 32'(off * 4);
      return seq;
   endfunction

   // Drive one complete fetch/hold/retire transaction and report observations
   task automatic run_instr(input logic [31:0] rdata, input int ack_wait, input int rdy_wait,
                            input logic br, input logic bne, input logic j, input logic z,
                            output logic found, output logic [31:0] fetch_addr,
                            output logic addr_stable, output logic got_valid,
                            output logic [31:0] held_instr, output logic [31:0] held_pc,
                            output logic held_stable);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      fetch_addr  = imem_addr;
      addr_stable = 1'b1;
      for (int k = 0; k < ack_wait; k++) begin
         imem_ack    = 1'b0;
         instr_ready = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         @(negedge clk);
         if (imem_req !== 1'b1 || imem_addr !== fetch_addr || instr_valid !== 1'b0)
            addr_stable = 1'b0;
      end
      imem_ack    = 1'b1;
      imem_rdata  = rdata;
      instr_ready = 1'b0;
      @(negedge clk);
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      got_valid   = instr_valid;
      held_instr  = instr;
      held_pc     = pc;
      held_stable = (imem_req === 1'b0) && (opcode === rdata[31:26]);
      for (int k = 0; k < rdy_wait; k++) begin
         instr_ready = 1'b0;
         imem_ack    = 1'($urandom_range(0, 1));
         branch      = 1'($urandom_range(0, 1));
         branch_ne   = 1'($urandom_range(0, 1));
         jump        = 1'($urandom_range(0, 1));
         zero        = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== held_instr ||
             pc !== held_pc || opcode !== rdata[31:26])
            held_stable = 1'b0;
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      branch      = br;
      branch_ne   = bne;
      jump        = j;
      zero        = z;
      @(negedge clk);
      instr_ready = 1'b0;
      branch      = 1'($urandom_range(0, 1));
      branch_ne   = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = '0;
      branch = 1'b0; branch_ne = 1'b0; jump = 1'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
      checks++; if (hi_pc !== 32'h2000_0000) begin errors++; $display("FAIL reset_pc_align: got %h want 20000000", hi_pc); end
`ifdef FETCH_COUNT_EN
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
      $display("txn reset pc=%h", pc);
   endtask

   task automatic test_first_fetch();
      logic [31:0] r;
      r = $urandom;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
         begin errors++; $display("FAIL first_fetch_addr: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = r;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== r || opcode !== r[31:26])
         begin errors++; $display("FAIL first_fetch_data: got valid=%b instr=%h want valid=1 instr=%h", instr_valid, instr, r); end
      instr_ready = 1'b1; branch = 1'b0; branch_ne = 1'b0; jump = 1'b0;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h4)
         begin errors++; $display("FAIL first_retire: got valid=%b addr=%h want valid=0 addr=00000004", instr_valid, imem_addr); end
      model_pc = 32'h4;
      model_count = 1;
      $display("txn first_fetch instr=%h next=%h", r, imem_addr);
   endtask

   task automatic test_branch();
      logic [31:0] case_instr [4];
      logic        case_br [4], case_bne [4], case_z [4];
      logic        found, astab, gv, hstab;
      logic [31:0] fa, hi_, hp, r, exp;
      case_instr[0] = {OP_BEQ, 10'd0, 16'hFFFF}; case_br[0] = 1; case_bne[0] = 0; case_z[0] = 1;
      case_instr[1] = {OP_BNE, 10'd0, 16'h0005}; case_br[1] = 0; case_bne[1] = 1; case_z[1] = 1;
      case_instr[2] = {OP_BEQ, 10'd0, 16'hFFFE}; case_br[2] = 1; case_bne[2] = 0; case_z[2] = 1;
      case_instr[3] = {OP_BNE, 10'd0, 16'h0005}; case_br[3] = 0; case_bne[3] = 1; case_z[3] = 0;
      for (int s = 0; s < 8 && model_pc != 32'h10; s++) begin
         r = {OP_RTYPE, 26'($urandom)};
         run_instr(r, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, 0, found, fa, astab, gv, hi_, hp, hstab);
         checks++; if (fa !== model_pc || !found) begin errors++; $display("FAIL walk_addr: got %h want %h", fa, model_pc); end
         model_pc = model_pc + 32'd4; model_count++;
         $display("txn walk instr=%h next=%h", r, imem_addr);
      end
      for (int c = 0; c < 4; c++) begin
         run_instr(case_instr[c], $urandom_range(0, 2), $urandom_range(0, 2), case_br[c], case_bne[c], 0, case_z[c],
                   found, fa, astab, gv, hi_, hp, hstab);
         exp = ref_next_pc(model_pc, case_instr[c], case_br[c], case_bne[c], 0, case_z[c]);
         checks++; if (gv !== 1'b1 || hp !== model_pc || hi_ !== case_instr[c])
            begin errors++; $display("FAIL branch%0d_hold: got valid=%b pc=%h instr=%h want 1 %h %h", c, gv, hp, hi_, model_pc, case_instr[c]); end
         checks++; if (imem_addr !== exp)
            begin errors++; $display("FAIL branch%0d_next: got %h want %h", c, imem_addr, exp); end
         model_pc = exp; model_count++;
         $display("txn branch%0d instr=%h next=%h", c, case_instr[c], imem_addr);
      end
   endtask

   task automatic test_stall();
      logic        found, astab, gv, hstab;
      logic [31:0] fa, hi_, hp, r;
      r = {OP_LW, 26'($urandom)};
      run_instr(r, 5, 3, 0, 0, 0, 0, found, fa, astab, gv, hi_, hp, hstab);
      checks++; if (astab !== 1'b1 || fa !== model_pc)
         begin errors++; $display("FAIL stall_addr: got stable=%b addr=%h want 1 %h", astab, fa, model_pc); end
      checks++; if (hstab !== 1'b1 || hi_ !== r || gv !== 1'b1)
         begin errors++; $display("FAIL stall_hold: got stable=%b instr=%h want 1 %h", hstab, hi_, r); end
      model_pc = model_pc + 32'd4; model_count++;
      checks++; if (imem_addr !== model_pc) begin errors++; $display("FAIL stall_next: got %h want %h", imem_addr, model_pc); end
      $display("txn stall instr=%h next=%h", r, imem_addr);
   endtask

   task automatic test_reset_mid_fetch();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0)
         begin errors++; $display("FAIL async_reset: got req=%b valid=%b pc=%h instr=%h want 0 0 0 0", imem_req, instr_valid, pc, instr); end
      @(negedge clk);
      imem_ack = 1'b1; imem_rdata = $urandom;
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0)
         begin errors++; $display("FAIL late_ack: got req=%b valid=%b addr=%h want 1 0 00000000", imem_req, instr_valid, imem_addr); end
      model_pc = 32'h0; model_count = 0;
      $display("txn reset_mid_fetch addr=%h", imem_addr);
   endtask

   task automatic test_jump();
      logic        found, astab, gv, hstab;
      logic [31:0] fa, hi_, hp, r, exp, exp_hi;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_pc = 32'h0; model_count = 0;
      checks++; if (hi_imem_addr !== 32'h2000_0000)
         begin errors++; $display("FAIL jump_hi_start: got %h want 20000000", hi_imem_addr); end
      r = {OP_J, 26'h000_0100};
      run_instr(r, 0, 1, 1, 0, 1, 1, found, fa, astab, gv, hi_, hp, hstab);
      exp    = ref_next_pc(model_pc, r, 1, 0, 1, 1);
      exp_hi = ref_next_pc(32'h2000_0000, r, 1, 0, 1, 1);
      checks++; if (imem_addr !== exp) begin errors++; $display("FAIL jump_next: got %h want %h", imem_addr, exp); end
      checks++; if (hi_imem_addr !== exp_hi) begin errors++; $display("FAIL jump_hi_next: got %h want %h", hi_imem_addr, exp_hi); end
      model_pc = exp; model_count++;
      $display("txn jump instr=%h next=%h hi_next=%h", r, imem_addr, hi_imem_addr);
   endtask

   task automatic test_wrap();
      logic        found, astab, gv, hstab;
      logic [31:0] fa, hi_, hp, r, t, exp;
      t = -(model_pc + 32'd8);
      t = t >> 2;
      r = {OP_BEQ, 10'd0, t[15:0]};
      run_instr(r, 1, 0, 1, 0, 0, 1, found, fa, astab, gv, hi_, hp, hstab);
      exp = ref_next_pc(model_pc, r, 1, 0, 0, 1);
      checks++; if (imem_addr !== exp || exp !== 32'hFFFF_FFFC)
         begin errors++; $display("FAIL wrap_setup: got %h want %h", imem_addr, exp); end
      model_pc = exp; model_count++;
      r = {OP_SW, 26'($urandom)};
      run_instr(r, 0, 0, 0, 0, 0, 0, found, fa, astab, gv, hi_, hp, hstab);
      exp = model_pc + 32'd4;
      checks++; if (imem_addr !== exp) begin errors++; $display("FAIL wrap_next: got %h want %h", imem_addr, exp); end
      model_pc = exp; model_count++;
`ifdef FETCH_COUNT_EN
      checks++; if (fetch_count !== 32'(model_count))
         begin errors++; $display("FAIL count_after_jump: got %0d want %0d", fetch_count, model_count); end
`endif
      $display("txn wrap next=%h", imem_addr);
   endtask

   task automatic test_random();
      logic        found, astab, gv, hstab, br, bne, j, z;
      logic [31:0] fa, hi_, hp, r, exp;
      for (int n = 0; n < 30; n++) begin
         r = $urandom; br = 1'($urandom_range(0, 1)); bne = 1'($urandom_range(0, 1));
         j = ($urandom_range(0, 3) == 0); z = 1'($urandom_range(0, 1));
         run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3), br, bne, j, z, found, fa, astab, gv, hi_, hp, hstab);
         exp = ref_next_pc(model_pc, r, br, bne, j, z);
         checks++; if (!found || fa !== model_pc || gv !== 1'b1 || hi_ !== r || !astab || !hstab)
            begin errors++; $display("FAIL rand%0d_txn: got addr=%h valid=%b instr=%h want %h 1 %h", n, fa, gv, hi_, model_pc, r); end
         checks++; if (imem_addr !== exp || pc !== exp)
            begin errors++; $display("FAIL rand%0d_next: got %h want %h", n, imem_addr, exp); end
         model_pc = exp; model_count++;
         $display("txn rand%0d instr=%h br=%b bne=%b j=%b z=%b next=%h", n, r, br, bne, j, z, imem_addr);
      end
`ifdef FETCH_COUNT_EN
      checks++; if (fetch_count !== 32'(model_count))
         begin errors++; $display("FAIL count_final: got %0d want %0d", fetch_count, model_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_branch();
      test_stall();
      test_reset_mid_fetch();
      test_jump();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
